// File: rtl/instructions.sv
// rtl/instructions.sv - shared ICU types: sequencer state and instruction word
// Purpose: types shared by the ICU sequencer and the blocks around it.
//   seq_state_t   : sequencer control state (IDLE/LOAD/RUN/HALT)
//   opcode_t      : 4-bit ICU opcode
//   instruction_t : opcode plus instruction address field
package instructions;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_LOAD = 2'd1,
    S_RUN  = 2'd2,
    S_HALT = 2'd3
  } seq_state_t;

  typedef enum logic [3:0] {
    OP_NOPO = 4'h0, OP_LD   = 4'h1, OP_LDC  = 4'h2, OP_AND  = 4'h3,
    OP_ANDC = 4'h4, OP_OR   = 4'h5, OP_ORC  = 4'h6, OP_XNOR = 4'h7,
    OP_STO  = 4'h8, OP_STOC = 4'h9, OP_IEN  = 4'hA, OP_OEN  = 4'hB,
    OP_JMP  = 4'hC, OP_RTN  = 4'hD, OP_SKZ  = 4'hE, OP_NOPF = 4'hF
  } opcode_t;

  localparam int unsigned INSTR_ADDR_W = 12;

  typedef struct packed {
    opcode_t                  opcode;
    logic [INSTR_ADDR_W-1:0]  addr;
  } instruction_t;

endpackage

// File: rtl/return_stack.sv
// rtl/return_stack.sv - LIFO of return addresses for the ICU sequencer
// Purpose: holds return addresses pushed by JMP and popped by RTN.
// Ports:
//   clk, rst            : clock, synchronous active-high reset (clears depth only)
//   push, push_data     : store push_data on top (caller never pushes when full)
//   pop                 : discard top entry (caller never pops when empty)
//   top                 : current top entry, valid while depth > 0
//   depth, full, empty  : occupancy
module return_stack #(
  parameter int ADDR        = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              push,
  input  logic [ADDR-1:0]                   push_data,
  input  logic                              pop,
  output logic [ADDR-1:0]                   top,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
  output logic                              full,
  output logic                              empty
);

  localparam int DW = $clog2(STACK_DEPTH+1);
  localparam int IW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [ADDR-1:0] mem_q [STACK_DEPTH];
  logic [DW-1:0]   depth_q;
  logic [IW-1:0]   wr_idx;
  logic [IW-1:0]   rd_idx;

  assign wr_idx = IW'(depth_q);
  assign rd_idx = IW'(depth_q - DW'(1));

  assign top   = mem_q[rd_idx];
  assign depth = depth_q;
  assign full  = (depth_q == DW'(STACK_DEPTH));
  assign empty = (depth_q == '0);

  always_ff @(posedge clk) begin
    if (rst) begin
      depth_q <= '0;
    end else if (push) begin
      depth_q <= depth_q + DW'(1);
    end else if (pop) begin
      depth_q <= depth_q - DW'(1);
    end
  end

  // Entries are not cleared on reset; depth alone decides what is valid.
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/icu_sequencer.sv
// rtl/icu_sequencer.sv - program counter sequencer for a 1-bit ICU
// Purpose: steps the program counter through load and run phases, handles
//   JMP/RTN through a return stack, SKZ skips and flag_f halts.
// Ports:
//   clk, rst              : clock, synchronous active-high reset
//   load_en, program_write: program load mode request / one word written
//   start                 : begin (from IDLE) or resume (from HALT)
//   jmp, rtn, skz, rr     : ICU control flags and result register
//   flag_f                : halt request
//   target                : jump address
//   pc, running, depth    : program address, RUN indicator, stack occupancy
//   err_ovf, err_unf      : sticky stack overflow / underflow
module icu_sequencer
  import instructions::*;
#(
  parameter int ADDR        = 12,
  parameter int STACK_DEPTH = 4
) (
  input  logic                              clk,
  input  logic                              rst,
  input  logic                              load_en,
  input  logic                              program_write,
  input  logic                              start,
  input  logic                              jmp,
  input  logic                              rtn,
  input  logic                              skz,
  input  logic                              rr,
  input  logic                              flag_f,
  input  logic [ADDR-1:0]                   target,
  output logic [ADDR-1:0]                   pc,
  output logic                              running,
  output logic [$clog2(STACK_DEPTH+1)-1:0]  depth,
  output logic                              err_ovf,
  output logic                              err_unf
);

  seq_state_t      state_q;
  logic [ADDR-1:0] pc_q;
  logic            running_q;
  logic            err_ovf_q;
  logic            err_unf_q;

  logic            stk_push;
  logic            stk_pop;
  logic [ADDR-1:0] stk_top;
  logic            stk_full;
  logic            stk_empty;
  logic            in_run;

  // Stack strobes follow the RUN priority: flag_f blocks all, rtn beats jmp,
  // so push and pop are never raised together.
  assign in_run   = (state_q == S_RUN);
  assign stk_pop  = in_run && !flag_f && rtn && !stk_empty;
  assign stk_push = in_run && !flag_f && !rtn && jmp && !stk_full;

  return_stack #(
    .ADDR        (ADDR),
    .STACK_DEPTH (STACK_DEPTH)
  ) u_return_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (stk_push),
    .push_data (pc_q + ADDR'(1)),
    .pop       (stk_pop),
    .top       (stk_top),
    .depth     (depth),
    .full      (stk_full),
    .empty     (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      pc_q      <= '0;
      running_q <= 1'b0;
      err_ovf_q <= 1'b0;
      err_unf_q <= 1'b0;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (load_en) begin
            state_q <= S_LOAD;
          end else if (start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
          end
        end
        S_LOAD: begin
          // Leaving load mode rewinds to address 0 for execution.
          if (!load_en) begin
            state_q <= S_IDLE;
            pc_q    <= '0;
          end else if (program_write) begin
            pc_q <= pc_q + ADDR'(1);
          end
        end
        S_RUN: begin
          if (flag_f) begin
            state_q   <= S_HALT;
            running_q <= 1'b0;
          end else if (rtn) begin
            if (stk_empty) begin
              pc_q      <= pc_q + ADDR'(1);
              err_unf_q <= 1'b1;
            end else begin
              pc_q <= stk_top;
            end
          end else if (jmp) begin
            // A full stack loses the return address but the jump is still taken.
            pc_q <= target;
            if (stk_full) begin
              err_ovf_q <= 1'b1;
            end
          end else if (skz && !rr) begin
            pc_q <= pc_q + ADDR'(2);
          end else begin
            pc_q <= pc_q + ADDR'(1);
          end
        end
        S_HALT: begin
          if (start) begin
            state_q   <= S_RUN;
            running_q <= 1'b1;
            pc_q      <= pc_q + ADDR'(1);
          end
        end
        default: begin
          state_q   <= S_IDLE;
          running_q <= 1'b0;
        end
      endcase
    end
  end

  assign pc      = pc_q;
  assign running = running_q;
  assign err_ovf = err_ovf_q;
  assign err_unf = err_unf_q;

endmodule

// File: tb/tb_icu_sequencer.sv
// tb/tb_icu_sequencer.sv - self-checking bench for icu_sequencer
module tb_icu_sequencer;

  localparam int ADDR  = 12;
  localparam int SD    = 4;
  localparam int PCMOD = 1 << ADDR;

  logic            clk;
  logic            rst;
  logic            load_en;
  logic            program_write;
  logic            start;
  logic            jmp;
  logic            rtn;
  logic            skz;
  logic            rr;
  logic            flag_f;
  logic [ADDR-1:0] target;
  logic [ADDR-1:0] pc;
  logic            running;
  logic [2:0]      depth;
  logic            err_ovf;
  logic            err_unf;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model: phase as a name, pc as an integer, stack as a queue.
  string m_phase;
  int    m_pc;
  int    m_stk[$];
  bit    m_ovf;
  bit    m_unf;

  icu_sequencer #(.ADDR(ADDR), .STACK_DEPTH(SD)) dut (
    .clk           (clk),
    .rst           (rst),
    .load_en       (load_en),
    .program_write (program_write),
    .start         (start),
    .jmp           (jmp),
    .rtn           (rtn),
    .skz           (skz),
    .rr            (rr),
    .flag_f        (flag_f),
    .target        (target),
    .pc            (pc),
    .running       (running),
    .depth         (depth),
    .err_ovf       (err_ovf),
    .err_unf       (err_unf)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
    end
  endtask

  task automatic clear_in();
    rst = 0; load_en = 0; program_write = 0; start = 0;
    jmp = 0; rtn = 0; skz = 0; rr = 0; flag_f = 0; target = '0;
  endtask

  task automatic model_step();
    if (rst) begin
      m_phase = "IDLE"; m_pc = 0; m_stk.delete(); m_ovf = 0; m_unf = 0;
    end else if (m_phase == "IDLE") begin
      if (load_en) m_phase = "LOAD";
      else if (start) m_phase = "RUN";
    end else if (m_phase == "LOAD") begin
      if (!load_en) begin
        m_phase = "IDLE"; m_pc = 0;
      end else if (program_write) begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end else if (m_phase == "RUN") begin
      if (flag_f) begin
        m_phase = "HALT";
      end else if (rtn) begin
        if (m_stk.size() > 0) m_pc = m_stk.pop_back();
        else begin m_pc = (m_pc + 1) % PCMOD; m_unf = 1; end
      end else if (jmp) begin
        if (m_stk.size() == SD) m_ovf = 1;
        else m_stk.push_back((m_pc + 1) % PCMOD);
        m_pc = int'(target);
      end else if (skz) begin
        m_pc = (m_pc + (rr ? 1 : 2)) % PCMOD;
      end else begin
        m_pc = (m_pc + 1) % PCMOD;
      end
    end else begin
      if (start) begin
        m_phase = "RUN"; m_pc = (m_pc + 1) % PCMOD;
      end
    end
  endtask

  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    check("pc", 32'(pc), 32'(m_pc));
    check("running", 32'(running), 32'(m_phase == "RUN"));
    check("depth", 32'(depth), 32'(m_stk.size()));
    check("err_ovf", 32'(err_ovf), 32'(m_ovf));
    check("err_unf", 32'(err_unf), 32'(m_unf));
  endtask

  initial begin
    clear_in();
    m_phase = "IDLE"; m_pc = 0; m_ovf = 0; m_unf = 0;
    @(negedge clk);

    // Reset state
    rst = 1; tick();
    check("rst_pc", 32'(pc), 32'h0);
    check("rst_depth", 32'(depth), 32'h0);
    check("rst_running", 32'(running), 32'h0);
    rst = 0;

    // Program load: five writes then exit
    load_en = 1; tick();
    program_write = 1;
    for (int i = 0; i < 5; i++) tick();
    check("load_pc5", 32'(pc), 32'h5);
    program_write = 0; load_en = 0; tick();
    check("load_exit_pc", 32'(pc), 32'h0);
    check("load_exit_running", 32'(running), 32'h0);

    // Call / return from pc=3
    start = 1; tick(); start = 0;
    check("start_running", 32'(running), 32'h1);
    for (int i = 0; i < 3; i++) tick();
    check("pc3", 32'(pc), 32'h3);
    jmp = 1; target = 12'h100; tick(); jmp = 0;
    check("call_pc", 32'(pc), 32'h100);
    check("call_depth", 32'(depth), 32'h1);
    rtn = 1; tick(); rtn = 0;
    check("ret_pc", 32'(pc), 32'h4);
    check("ret_depth", 32'(depth), 32'h0);

    // Overflow then underflow
    jmp = 1;
    for (int i = 1; i <= 5; i++) begin
      target = 12'(i * 16); tick();
    end
    jmp = 0;
    check("ovf_depth", 32'(depth), 32'h4);
    check("ovf_flag", 32'(err_ovf), 32'h1);
    check("ovf_pc", 32'(pc), 32'h50);
    rtn = 1;
    for (int i = 0; i < 4; i++) tick();
    check("unf_not_yet", 32'(err_unf), 32'h0);
    check("pop4_pc", 32'(pc), 32'h5);
    tick(); rtn = 0;
    check("unf_flag", 32'(err_unf), 32'h1);
    check("unf_pc", 32'(pc), 32'h6);

    // Skip and wrap
    jmp = 1; target = 12'hFFE; tick(); jmp = 0;
    skz = 1; rr = 0; tick(); skz = 0;
    check("skz_wrap", 32'(pc), 32'h0);
    jmp = 1; target = 12'hFFF; tick(); jmp = 0;
    tick();
    check("inc_wrap", 32'(pc), 32'h0);
    skz = 1; rr = 1; tick(); skz = 0; rr = 0;
    check("skz_rr1", 32'(pc), 32'h1);

    // Priority and halt at pc=7
    jmp = 1; target = 12'h7; tick(); jmp = 0;
    flag_f = 1; rtn = 1; jmp = 1; target = 12'h55; tick();
    flag_f = 0; rtn = 0; jmp = 0;
    check("halt_pc", 32'(pc), 32'h7);
    check("halt_depth", 32'(depth), 32'h3);
    check("halt_running", 32'(running), 32'h0);
    jmp = 1; target = 12'h99; tick(); jmp = 0;
    check("halt_ignores_jmp", 32'(pc), 32'h7);
    start = 1; tick(); start = 0;
    check("resume_pc", 32'(pc), 32'h8);

    // Reset mid-run
    rtn = 1; tick(); rtn = 0;
    check("pre_rst_depth", 32'(depth), 32'h2);
    rst = 1; jmp = 1; start = 1; load_en = 1; tick(); clear_in();
    check("midrun_rst_pc", 32'(pc), 32'h0);
    check("midrun_rst_depth", 32'(depth), 32'h0);
    check("midrun_rst_ovf", 32'(err_ovf), 32'h0);
    check("midrun_rst_running", 32'(running), 32'h0);

    // Randomised traffic against the model
    for (int n = 0; n < 3000; n++) begin
      rst           = ($urandom_range(63) == 0);
      load_en       = ($urandom_range(11) == 0);
      program_write = $urandom_range(1) == 1;
      start         = ($urandom_range(3) == 0);
      jmp           = ($urandom_range(3) == 0);
      rtn           = ($urandom_range(3) == 0);
      skz           = ($urandom_range(2) == 0);
      rr            = $urandom_range(1) == 1;
      flag_f        = ($urandom_range(15) == 0);
      target        = 12'($urandom);
      tick();
    end
    clear_in();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/icu_sequencer.md
ICU_SEQUENCER -- requirements
Module: icu_sequencer

Interface
REQ-001 SHALL have parameter ADDR, default 12: program address width.
REQ-002 SHALL have parameter STACK_DEPTH, default 4: return-stack entries (>=1).
REQ-003 SHALL have port clk, input, 1: single clock, all state on rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port load_en, input, 1: request program-load mode.
REQ-006 SHALL have port program_write, input, 1: one program word written this cycle (load mode).
REQ-007 SHALL have port start, input, 1: begin/resume execution.
REQ-008 SHALL have port jmp, input, 1: ICU JMP flag, jump to target and push return address.
REQ-009 SHALL have port rtn, input, 1: ICU RTN flag, pop return address.
REQ-010 SHALL have port skz, input, 1: skip next instruction if rr==0.
REQ-011 SHALL have port rr, input, 1: ICU result register.
REQ-012 SHALL have port flag_f, input, 1: halt request.
REQ-013 SHALL have port target, input, ADDR: jump address (instruction address field).
REQ-014 SHALL have port pc, output, ADDR: fetch/write address for program memory.
REQ-015 SHALL have port running, output, 1: high in RUN.
REQ-016 SHALL have port depth, output, $clog2(STACK_DEPTH+1): return-stack occupancy.
REQ-017 SHALL have ports err_ovf and err_unf, output, 1 each: sticky stack overflow/underflow.

Function
REQ-018 SHALL implement states IDLE, LOAD, RUN, HALT.
REQ-019 IDLE: load_en -> LOAD; else start -> RUN; load_en wins if both high.
REQ-020 LOAD: pc increments by 1 on each program_write cycle; load_en low -> IDLE with pc=0 next cycle.
REQ-021 RUN: control inputs sampled every cycle, pc updated next cycle; priority flag_f > rtn > jmp > skz > increment.
REQ-022 flag_f in RUN: pc holds, -> HALT; HALT + start -> RUN resuming at pc+1.
REQ-023 rtn with depth>0: pc <= top entry, depth-1; with depth==0: pc <= pc+1, err_unf set.
REQ-024 jmp: pc <= target, pc+1 pushed; if depth==STACK_DEPTH, push dropped, err_ovf set, jump still taken.
REQ-025 skz with rr==0: pc <= pc+2; rr==1: pc <= pc+1.
REQ-026 All pc arithmetic modulo 2^ADDR (max+1 -> 0, max+2 -> 1); pushed pc+1 also wraps.
REQ-027 Control inputs ignored outside RUN; program_write ignored outside LOAD.
REQ-028 err flags clear only on rst.

Reset
REQ-029 rst SHALL force IDLE, pc=0, depth=0, running=0, err_ovf=0, err_unf=0 on next edge, overriding all inputs in any state, mid-load or mid-run.
REQ-030 Stack contents need not be cleared; only depth governs validity.

Structure
REQ-031 State enum seq_state_t SHALL live in shared package instructions alongside instruction_t.
REQ-032 Return stack SHALL be sub-module return_stack (push, pop, top, depth, full, empty; parameters ADDR, STACK_DEPTH; simultaneous push+pop never issued).
REQ-033 No combinational path from inputs to outputs; all outputs registered.

Verification
REQ-034 Load: rst, load_en=1, 5 program_write pulses -> pc=5; load_en=0 -> IDLE, pc=0.
REQ-035 Call/return: RUN at pc=3, jmp target=0x100 -> pc=0x100, depth=1; rtn -> pc=4, depth=0.
REQ-036 Overflow: STACK_DEPTH=4, 5 consecutive jmp -> depth=4, err_ovf=1, pc=last target; 5 rtn -> 4 pops then err_unf=1.
REQ-037 Skip/wrap: pc=0xFFE, skz rr=0 -> pc=0x000; pc=0xFFF, increment -> 0x000.
REQ-038 Priority/halt: flag_f+rtn+jmp same cycle at pc=7 -> HALT, pc=7, depth unchanged; start -> pc=8.
REQ-039 Reset mid-run: depth=2, err_ovf=1, rst -> all outputs zero, IDLE, next cycle.
